// File: rtl/chrisruk_frame_sched.sv
// Frame scheduler for an 8x8 APA102-style LED matrix: two-source
// round-robin frame grant, pixel fetch and serial clock/data engine.
module chrisruk_frame_sched #(
  parameter int N_PIXELS   = 64,
  parameter int END_BITS   = 64,
  parameter int GAP_CYCLES = 16,
  localparam int AW = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          busy,
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  input  logic [31:0]   pix_word0,
  input  logic [31:0]   pix_word1,
  output logic          led_clk,
  output logic          led_dat
);

  localparam int EW = (END_BITS > 32) ? END_BITS : 32;
  localparam int BW = $clog2(EW);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [BW-1:0] WORD_LAST = BW'(31);
  localparam logic [BW-1:0] END_LAST  = BW'(END_BITS - 1);
  localparam logic [AW-1:0] PIX_LAST  = AW'(N_PIXELS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PIXEL,
    S_END,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [31:0]   shift_q, shift_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          last_q, last_d;
  logic [GW-1:0] gap_q, gap_d;

  logic          word_end;
  logic          end_last;
  logic          last_pix;
  logic          active;
  logic [1:0]    pick;
  logic [31:0]   sel_word;

  assign word_end = phase_q & (bit_q == WORD_LAST);
  assign end_last = phase_q & (bit_q == END_LAST);
  assign last_pix = (pix_q == PIX_LAST);
  assign sel_word = gnt_q[1] ? pix_word1 : pix_word0;
  assign active   = (state_q == S_START) |
                    (state_q == S_PIXEL) |
                    (state_q == S_END);

  // Both requesting: favour the source that did not win last time.
  always_comb begin
    pick = 2'b00;
    unique case (1'b1)
      (req == 2'b01): pick = 2'b01;
      (req == 2'b10): pick = 2'b10;
      (req == 2'b11): pick = last_q ? 2'b01 : 2'b10;
      default:        pick = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    shift_d = shift_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    last_d  = last_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick != 2'b00) begin
          gnt_d   = pick;
          last_d  = pick[1];
          state_d = S_START;
          phase_d = 1'b0;
          bit_d   = '0;
          pix_d   = '0;
          shift_d = '0;
        end
      end
      S_START: begin
        phase_d = ~phase_q;
        if (word_end) begin
          bit_d   = '0;
          shift_d = sel_word;
          state_d = S_PIXEL;
        end else if (phase_q) begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q << 1;
        end
      end
      S_PIXEL: begin
        phase_d = ~phase_q;
        if (word_end) begin
          bit_d = '0;
          if (last_pix) begin
            shift_d = '0;
            state_d = S_END;
          end else begin
            pix_d   = pix_q + 1'b1;
            shift_d = sel_word;
          end
        end else if (phase_q) begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q << 1;
        end
      end
      S_END: begin
        phase_d = ~phase_q;
        if (end_last) begin
          done_d  = gnt_q;
          gnt_d   = 2'b00;
          phase_d = 1'b0;
          bit_d   = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (phase_q) begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q << 1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      bit_q   <= '0;
      pix_q   <= '0;
      shift_q <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      last_q  <= 1'b1;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      shift_q <= shift_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  // Fetch the next word during phase 1 of the current word's last bit.
  always_comb begin
    pix_rd   = 1'b0;
    pix_addr = '0;
    if (state_q == S_START) begin
      pix_rd = word_end;
    end else if (state_q == S_PIXEL) begin
      pix_rd   = word_end & ~last_pix;
      pix_addr = last_pix ? pix_q : pix_q + 1'b1;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);
  assign led_clk = active & phase_q;
  assign led_dat = active & shift_q[31];

endmodule

// File: tb/tb_chrisruk_frame_sched.sv
// Scoreboard bench for chrisruk_frame_sched: frame-level reference model
// predicts grants and serial streams, a negedge monitor checks them.
module tb_chrisruk_frame_sched;

  localparam int NP     = 64;
  localparam int EB     = 64;
  localparam int GC     = 16;
  localparam int NBITS  = 32 + 32 * NP + EB;
  localparam int FRAME  = 2 * NBITS;
  localparam int SETTLE = FRAME + GC + 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        busy;
  logic        pix_rd;
  logic [5:0]  pix_addr;
  logic [31:0] pix_word0;
  logic [31:0] pix_word1;
  logic        led_clk;
  logic        led_dat;

  logic [31:0] mem0 [NP];
  logic [31:0] mem1 [NP];

  assign pix_word0 = mem0[pix_addr];
  assign pix_word1 = mem1[pix_addr];

  chrisruk_frame_sched #(
    .N_PIXELS(NP),
    .END_BITS(EB),
    .GAP_CYCLES(GC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .gnt(gnt),
    .done(done),
    .busy(busy),
    .pix_rd(pix_rd),
    .pix_addr(pix_addr),
    .pix_word0(pix_word0),
    .pix_word1(pix_word1),
    .led_clk(led_clk),
    .led_dat(led_dat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]        g;
    logic               src;
    logic [NP*32-1:0]   w;
  } frame_t;

  frame_t exp_q[$];
  int     done_log[$];
  int     cyc = 0;
  int     m_idle = 0;
  int     m_flush = 0;
  int     m_rst_cyc = 0;
  logic   m_last = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, expv, cyc);
    end
  endtask

  function automatic logic exp_bit(input frame_t f, input int i);
    int p;
    int b;
    if (i < 32 || i >= 32 + 32 * NP) return 1'b0;
    p = (i - 32) / 32;
    b = 31 - ((i - 32) % 32);
    return f.w[p*32 + b];
  endfunction

  // Reference model: a frame is one grant, then the link is busy for
  // the frame, the done cycle and the gap before the next decision.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_last    = 1'b1;
      m_idle    = cyc;
      m_flush   = exp_q.size();
      m_rst_cyc = cyc;
    end else if (cyc - 1 >= m_idle && req != 2'b00) begin
      frame_t f;
      logic   s;
      if (req == 2'b11) s = m_last ? 1'b0 : 1'b1;
      else s = req[1];
      f.g   = cyc;
      f.src = s;
      for (int p = 0; p < NP; p++)
        f.w[p*32 +: 32] = s ? mem1[p] : mem0[p];
      exp_q.push_back(f);
      m_last = s;
      m_idle = cyc + FRAME + 1 + GC;
    end
  end

  int     rd_idx = 0;
  int     rel;
  int     rd_cnt;
  int     gnt_err;
  int     clk_err;
  int     rd_err;
  int     idle_err = 0;
  int     last_done = -1;
  int     nb;
  logic   bits[$];
  frame_t cur;
  logic [1:0] oh;
  logic   bsy;

  initial forever begin
    @(negedge clk);
    if (rd_idx < m_flush) rd_idx = m_flush;
    if (rd_idx < exp_q.size() && cyc >= int'(exp_q[rd_idx].g)) begin
      cur = exp_q[rd_idx];
      rel = cyc - int'(cur.g);
      oh  = cur.src ? 2'b10 : 2'b01;
      if (rel == 0) begin
        bits.delete();
        rd_cnt  = 0;
        gnt_err = 0;
        clk_err = 0;
        rd_err  = 0;
      end
      if (rel < FRAME) begin
        if (gnt !== oh || busy !== 1'b1 || done !== 2'b00) gnt_err++;
        if (led_clk !== rel[0]) clk_err++;
        if (led_clk === 1'b1) bits.push_back(led_dat);
        if (pix_rd === 1'b1) begin
          if (rel != 64 * (rd_cnt + 1) - 1 || int'(pix_addr) != rd_cnt)
            rd_err++;
          rd_cnt++;
        end
      end else begin
        check("done_pulse", done, oh);
        check("done_cycle_outs", {gnt, busy, led_clk, led_dat}, 5'b00100);
        check("bit_count", bits.size(), NBITS);
        nb = 0;
        for (int i = 0; i < bits.size(); i++)
          if (bits[i] !== exp_bit(cur, i)) nb++;
        check("stream_bits", nb, 0);
        check("pix_rd_count", rd_cnt, NP);
        check("pix_rd_timing", rd_err, 0);
        check("gnt_busy_frame", gnt_err, 0);
        check("led_clk_phase", clk_err, 0);
        done_log.push_back(int'(cur.src));
        last_done = cyc;
        rd_idx++;
      end
    end else begin
      bsy = (last_done > m_rst_cyc) && (cyc > last_done) &&
            (cyc <= last_done + GC);
      if (gnt !== 2'b00 || done !== 2'b00 || pix_rd !== 1'b0 ||
          led_clk !== 1'b0 || led_dat !== 1'b0 || busy !== bsy)
        idle_err++;
    end
  end

  task automatic wait_pix(input int a, output logic found);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (pix_rd === 1'b1 && int'(pix_addr) == a) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic fill_random();
    for (int p = 0; p < NP; p++) begin
      mem0[p] = $urandom;
      mem1[p] = $urandom;
    end
  endtask

  logic found;
  int   dl0;

  initial begin
    for (int p = 0; p < NP; p++) begin
      mem0[p] = 32'h0;
      mem1[p] = 32'h0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_pix_rd", pix_rd, 1'b0);
    check("rst_pix_addr", pix_addr, 6'd0);
    check("rst_led_clk", led_clk, 1'b0);
    check("rst_led_dat", led_dat, 1'b0);

    for (int p = 0; p < NP; p++) begin
      mem0[p] = 32'hE000_0000 | p;
      mem1[p] = $urandom;
    end
    reset = 1'b0;
    req   = 2'b01;
    @(negedge clk);
    check("gnt_after_req", gnt, 2'b01);
    check("led_clk_phase0", led_clk, 1'b0);
    req = 2'b00;
    @(negedge clk);
    check("led_clk_first_rise", led_clk, 1'b1);
    repeat (SETTLE) @(negedge clk);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fill_random();
    mem0[0]      = 32'hFFFF_FFFF;
    mem0[NP - 1] = 32'h0000_0001;
    mem1[0]      = 32'hFFFF_FFFF;
    mem1[NP - 1] = 32'h0000_0001;
    dl0 = done_log.size();
    req = 2'b11;
    repeat (3 * (FRAME + GC + 2) - 200) @(negedge clk);
    req = 2'b00;
    repeat (SETTLE) @(negedge clk);
    check("fair_frames", done_log.size() - dl0, 3);
    for (int k = 0; k < 3 && dl0 + k < done_log.size(); k++)
      check("fair_order", done_log[dl0 + k], k % 2);

    fill_random();
    req = 2'b10;
    wait_pix(10, found);
    check("reach_pix10", found, 1'b1);
    req = 2'b00;
    dl0 = done_log.size();
    repeat (SETTLE) @(negedge clk);
    check("drop_done_count", done_log.size() - dl0, 1);
    check("drop_done_src", done_log[done_log.size() - 1], 1);
    check("drop_idle_gnt", gnt, 2'b00);
    check("drop_idle_busy", busy, 1'b0);

    req = 2'b01;
    wait_pix(20, found);
    check("reach_pix20", found, 1'b1);
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clk);
    check("midrst_led_clk", led_clk, 1'b0);
    check("midrst_led_dat", led_dat, 1'b0);
    check("midrst_gnt", gnt, 2'b00);
    check("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    req   = 2'b10;
    @(negedge clk);
    check("midrst_regrant", gnt, 2'b10);
    req = 2'b00;
    repeat (SETTLE) @(negedge clk);

    fill_random();
    for (int it = 0; it < 12; it++) begin
      req = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 2500)) @(negedge clk);
    end
    req = 2'b00;
    repeat (SETTLE) @(negedge clk);

    check("scoreboard_drained", exp_q.size() - rd_idx, 0);
    check("idle_outputs", idle_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chrisruk_frame_sched.md
# chrisruk_frame_sched

Frame scheduler and serial-link owner for the 8x8 LED matrix. It arbitrates between two frame sources, such as the scrolling-font renderer and a test-pattern generator, and grants the matrix link to one source for a whole frame. During the frame it fetches 32-bit pixel words from the granted source and serialises them onto the APA102-style clock/data pair. The frame format is a zero start frame, one word per LED, then a zero end frame, followed by an enforced inter-frame gap.

## Interface
Parameters:
- N_PIXELS, 64: LEDs per frame; pixel address width AW = clog2(N_PIXELS).
- END_BITS, 64: zero bits in the end frame (≥1).
- GAP_CYCLES, 16: idle clk cycles between frames (≥1).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- req  in  2  level frame requests; req[i] means source i has a frame ready.
- gnt  out  2  one-hot grant, held for the entire frame.
- done  out  2  one-cycle pulse to source i when its frame completes.
- busy  out  1  high in every state except IDLE.
- pix_rd  out  1  one-cycle pixel-fetch strobe to the granted source.
- pix_addr  out  AW  pixel index 0..N_PIXELS-1, valid while pix_rd is high.
- pix_word0  in  32  pixel word from source 0, sampled the cycle after pix_rd.
- pix_word1  in  32  pixel word from source 1, sampled the cycle after pix_rd.
- led_clk  out  1  matrix serial clock.
- led_dat  out  1  matrix serial data.

## Operation
- **States:** IDLE, START, PIXEL, END, GAP.
- **Reset values:** state=IDLE, gnt=0, done=0, busy=0, pix_rd=0, pix_addr=0, led_clk=0, led_dat=0, last_gnt=1. With last_gnt=1, source 0 wins the first tie.
- **IDLE:**
  - If no req is set, stay in IDLE.
  - If exactly one req is set, grant that source.
  - If both are set, grant the source that is not last_gnt.
  - When a grant is made: gnt is registered, last_gnt is updated, and the state moves to START.
- **Bit engine:** every bit occupies 2 clk cycles.
  - Phase 0: led_clk=0 and led_dat takes the new bit.
  - Phase 1: led_clk=1 and led_dat is held.
  - Words are sent MSB first.
- **START:** 32 bits of 0.
- **PIXEL:** N_PIXELS words.
  - pix_rd pulses in phase 1 of the last bit of the preceding word. For pixel 0, the preceding word is start-frame bit 31.
  - pix_addr equals the next pixel index at that time.
  - The word from the granted source (pix_word0 or pix_word1, selected by gnt) is loaded into a 32-bit shift register on the next cycle. That cycle is phase 0 of the word's bit 31.
  - No pix_rd is issued after the last pixel.
- **END:** END_BITS bits of 0.
- **Frame completion:** the cycle after phase 1 of the last END bit:
  - done[granted] = 1 for one cycle;
  - gnt goes to 0;
  - led_clk = 0 and led_dat = 0;
  - state moves to GAP.
- **GAP:** counts GAP_CYCLES cycles with outputs idle, then returns to IDLE. A req seen in the IDLE cycle is granted at the next edge.
- **Frame integrity:**
  - Deasserting req mid-frame does not abort the frame; done still pulses.
  - A new req during a frame waits and never preempts the current frame.
- **Fairness:** if both sources hold req continuously, grants alternate 0,1,0,1,...
- **Counters:**
  - The bit counter wraps exactly at 32 within a word.
  - The pixel counter stops at N_PIXELS-1; pix_addr never exceeds N_PIXELS-1.
  - All counters are unsigned; no overflow is permitted at the parameter defaults.
- **Mid-operation reset:** reset applied in any state returns every register to its reset value on that edge. The next frame restarts from START; there is no partial resume.

## Timing
- Request to grant: req sampled in IDLE at edge t gives gnt=1 and state=START from t+1. First phase 0 (bit 0 of the start frame) is at t+1.
- Frame length in START..END: 2·(32 + 32·N_PIXELS + END_BITS) cycles. At defaults this is 2·2144 = 4288 cycles.
- pix_rd to data capture: exactly 1 cycle; the source must present its word combinationally or from a register within that cycle.
- done timing: 1 cycle after the last END phase 1.
- Minimum req-to-req period for one source running back-to-back: 1 (grant) + 4288 + 1 (done) + GAP_CYCLES + 1 (IDLE). These contributions sum to 4307 cycles at defaults.
- led_clk period: 2 cycles, 50% duty. led_dat is stable for the full high phase.

## Test plan
- **Reset state:** hold reset 3 cycles → all outputs 0; first rise of req[0] at cycle t → gnt=01 at t+1; led_clk rises at t+2.
- **Single frame, source 0:**
  - Stimulus: pix_word0 = 0xE0000000 | addr for every pixel.
  - Required: the captured serial stream is 32 zeros, then the 64 words in address order, then 64 zeros.
  - pix_rd pulses exactly 64 times; done[0] pulses once, 4288 cycles after the first START cycle.
- **Simultaneous requests after reset:**
  - Stimulus: req=11 held.
  - Required: gnt sequence 01, 10, 01; each done goes to the granted source; gap ≥16 cycles with busy=1 in GAP.
- **req drop mid-frame:** deassert req[1] at pixel 10 → frame still completes with all 64 words, done[1] pulses, then IDLE with gnt=00.
- **Reset mid-frame:** assert reset during PIXEL at pix_addr=20 → next cycle led_clk=0, led_dat=0, gnt=00, busy=0. A following req[1] starts a fresh START frame.
- **Boundary words:**
  - pix_word = 0xFFFFFFFF at addr 0 and 0x00000001 at addr 63.
  - Required: no extra or missing bits at word boundaries; the last pixel's LSB is immediately followed by END zeros.
